// File: rtl/adder_pkg.sv
// adder_pkg: types and defaults shared by the sequential chunked adder.
//   state_t    - controller states (IDLE, RUN, DONE)
//   DEF_WIDTH  - default operand/sum width
//   DEF_CHUNK  - default bits added per clock
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple-carry adder slice.
//   a, b   in  CHUNK  operand slices
//   ci     in  1      carry into bit 0
//   s      out CHUNK  sum slice
//   co     out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (feeds signed-overflow detection)
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/adder_seq_nbit.sv
// adder_seq_nbit: multi-cycle adder/subtractor that adds CHUNK bits per clock
// through a single adder_chunk slice, NCHUNK = WIDTH/CHUNK cycles per result.
//   clk, rst_n           clock, synchronous active-low reset
//   A, B, Cin, Sub       operands/mode, sampled when in_valid && in_ready
//   in_valid, in_ready   operand handshake (ready only when idle)
//   out_valid, out_ready result handshake (result held until accepted)
//   Sum, Cout            WIDTH-bit result (mod 2^WIDTH) and raw carry out
//   Ovf                  signed overflow, present only with ADDER_SEQ_OVF_EN
module adder_seq_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic             Ovf
`endif
);

  // Guarded divisor so a bad CHUNK reports the error below instead of a divide-by-zero.
  localparam int CH_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK  = WIDTH / CH_SAFE;
  localparam int KW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if ((CHUNK < 1) || ((WIDTH % CH_SAFE) != 0)) begin : g_bad_cfg
    $error("adder_seq_nbit: CHUNK must be >= 1 and divide WIDTH");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [KW-1:0]    k;
  logic             last;

  logic [CHUNK-1:0] ch_s;
  logic             ch_co, ch_msb;

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    last      = (k == K_LAST);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_r[int'(k)*CHUNK +: CHUNK]),
    .b     (b_r[int'(k)*CHUNK +: CHUNK]),
    .ci    (carry),
    .s     (ch_s),
    .co    (ch_co),
    .c_msb (ch_msb)
  );

  // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in
  // as the initial carry, so the RUN loop is identical for both modes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      k     <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= A;
          b_r   <= Sub ? ~B : B;
          carry <= Sub ? 1'b1 : Cin;
          k     <= '0;
        end
        RUN: begin
          Sum[int'(k)*CHUNK +: CHUNK] <= ch_s;
          carry <= ch_co;
          k     <= last ? '0 : k + KW'(1);
          if (last) Cout <= ch_co;
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_SEQ_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n)                   Ovf <= 1'b0;
    else if (state == RUN && last) Ovf <= ch_msb ^ ch_co;
  end
`else
  logic unused_msb;
  assign unused_msb = ch_msb;
`endif

endmodule

// File: tb/tb_adder_seq_nbit.sv
// tb_adder_seq_nbit: directed-vector bench for adder_seq_nbit.
//   u_dut : WIDTH=16, CHUNK=4  (4-cycle latency)
//   u_d1  : WIDTH=16, CHUNK=16 (1-cycle latency)
// Ovf checks are compiled in only with ADDER_SEQ_OVF_EN.
module tb_adder_seq_nbit;

  localparam int W  = 16;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, in_valid, in_ready, out_valid, out_ready, cout;
  logic [W-1:0] a1, b1, sum1;
  logic         cin1, sub1, in_valid1, in_ready1, out_valid1, out_ready1, cout1;
`ifdef ADDER_SEQ_OVF_EN
  logic ovf, ovf1;
`endif

  adder_seq_nbit #(.WIDTH(W), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .Sub(sub),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout)
`ifdef ADDER_SEQ_OVF_EN
    , .Ovf(ovf)
`endif
  );

  adder_seq_nbit #(.WIDTH(W), .CHUNK(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .Sum(sum1), .Cout(cout1)
`ifdef ADDER_SEQ_OVF_EN
    , .Ovf(ovf1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op on u_dut and wait (bounded) for out_valid; lat = edges after accept.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, output int lat);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_drop", out_valid, 0);
    chk("rdy_back", in_ready, 1);
  endtask

  task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tc, input logic ts,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    start_op(ta, tb, tc, ts, lat);
    chk({tag, "_lat"}, lat, NC);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
`ifdef ADDER_SEQ_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unreachable");
`endif
    finish_op();
  endtask

  initial begin
    int lat;
    logic [W-1:0] hs;
    logic         hc;

    rst_n = 1'b0; a = '0; b = '0; cin = 0; sub = 0; in_valid = 1'b1; out_ready = 0;
    a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; in_valid1 = 1'b1; out_ready1 = 0;

    // reset with in_valid held high: reset wins
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 0);
`ifdef ADDER_SEQ_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    in_valid = 0; in_valid1 = 0;
    rst_n = 1'b1;

    op("add1",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    op("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("subn",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op("subov", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op("cin",   16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    op("cinwr", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // backpressure in DONE: result holds, extra in_valid ignored
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    chk("bp_lat", lat, NC);
    hs = sum; hc = cout;
    chk("bp_sum0", hs, 16'h5555);
    for (int i = 0; i < 5; i++) begin
      a = 16'hAAAA; b = 16'h1111; in_valid = i[0];
      @(negedge clk);
      chk("bp_ov", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_sum", sum, 16'h5555);
      chk("bp_cout", cout, hc);
    end
    in_valid = 0;
    finish_op();
    // the ignored pulses must not have started an op
    repeat (6) @(negedge clk);
    chk("bp_nocap", out_valid, 0);

    // reset on the 2nd RUN cycle aborts the op
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 0; sub = 0; in_valid = 1'b1;
    @(negedge clk);              // accept edge done, RUN k=0
    in_valid = 0;
    @(negedge clk);              // first RUN edge done
    rst_n = 1'b0;
    @(negedge clk);              // second RUN edge saw reset
    rst_n = 1'b1;
    chk("ab_ready", in_ready, 1);
    chk("ab_sum", sum, 16'h0000);
    chk("ab_cout", cout, 0);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) lat++;
      @(negedge clk);
    end
    chk("ab_noov", lat, 0);
    op("after", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

    // CHUNK = WIDTH: single-cycle latency
    @(negedge clk);
    chk("c16_rdy", in_ready1, 1);
    a1 = 16'h7FFF; b1 = 16'h0001; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 0;
    chk("c16_run", out_valid1, 0);
    @(negedge clk);
    chk("c16_ov", out_valid1, 1);
    chk("c16_sum", sum1, 16'h8000);
    chk("c16_cout", cout1, 0);
`ifdef ADDER_SEQ_OVF_EN
    chk("c16_ovf", ovf1, 1);
`endif
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 0;
    chk("c16_back", in_ready1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
